// File: rtl/mlp_layer_scheduler.sv
// Sequences one shared fully-connected engine over NUM_LAYERS layers, steering ping-pong buffer selects.
// Define SCHED_WATCHDOG_EN to add a per-layer RUN watchdog that raises a sticky err and ends the run.
module mlp_layer_scheduler #(
    parameter int NUM_LAYERS     = 3,
    parameter int DIM_WIDTH      = 12,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [NUM_LAYERS*DIM_WIDTH-1:0] cfg_in_depth,
    input  logic [NUM_LAYERS*DIM_WIDTH-1:0] cfg_out_depth,
    input  logic                            eng_done,
    output logic                            eng_start,
    output logic [DIM_WIDTH-1:0]            eng_in_depth,
    output logic [DIM_WIDTH-1:0]            eng_out_depth,
    output logic                            eng_relu,
    output logic [1:0]                      buf_rd_sel,
    output logic [1:0]                      buf_wr_sel,
    output logic [$clog2(NUM_LAYERS):0]     layer_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [CNT_WIDTH-1:0]            cycle_count
);

    localparam int IDX_W = $clog2(NUM_LAYERS) + 1;
    localparam int CFG_W = NUM_LAYERS * DIM_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    if (NUM_LAYERS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mlp_layer_scheduler: NUM_LAYERS and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_GAP,
        S_FINISH
    } state_t;

    state_t               state;
    logic [CFG_W-1:0]     in_lat;
    logic [CFG_W-1:0]     out_lat;

    int                   ld_idx;
    logic [CFG_W-1:0]     src_in;
    logic [CFG_W-1:0]     src_out;
    logic [DIM_WIDTH-1:0] ld_in;
    logic [DIM_WIDTH-1:0] ld_out;
    logic [1:0]           ld_rd;
    logic [1:0]           ld_wr;
    logic                 ld_relu;
    logic [IDX_W-1:0]     ld_layer;
    logic                 load_en;
    logic                 is_last;

    function automatic logic [DIM_WIDTH-1:0] pick(input logic [CFG_W-1:0] vec, input int idx);
        pick = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i == idx) begin
                pick = vec[i*DIM_WIDTH +: DIM_WIDTH];
            end
        end
    endfunction

    // Settings for the layer about to launch: layer 0 straight from cfg at
    // acceptance (latch happens on the same edge), later layers from the latch.
    always_comb begin
        ld_idx   = (state == S_IDLE) ? 0 : int'(layer_idx) + 1;
        src_in   = (state == S_IDLE) ? cfg_in_depth  : in_lat;
        src_out  = (state == S_IDLE) ? cfg_out_depth : out_lat;
        ld_in    = pick(src_in, ld_idx);
        ld_out   = pick(src_out, ld_idx);
        ld_wr    = ld_idx[0] ? 2'd2 : 2'd1;
        ld_rd    = (ld_idx == 0) ? 2'd0 : (ld_idx[0] ? 2'd1 : 2'd2);
        ld_relu  = (ld_idx != NUM_LAYERS - 1);
        ld_layer = IDX_W'(ld_idx);
        load_en  = !abort && ((state == S_IDLE && start) || state == S_GAP);
        is_last  = (int'(layer_idx) == NUM_LAYERS - 1);
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            in_lat        <= '0;
            out_lat       <= '0;
            eng_start     <= 1'b0;
            eng_in_depth  <= '0;
            eng_out_depth <= '0;
            eng_relu      <= 1'b0;
            buf_rd_sel    <= 2'd0;
            buf_wr_sel    <= 2'd0;
            layer_idx     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cycle_count   <= '0;
`ifdef SCHED_WATCHDOG_EN
            err           <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && !abort && cycle_count != CNT_MAX) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (load_en) begin
                eng_in_depth  <= ld_in;
                eng_out_depth <= ld_out;
                eng_relu      <= ld_relu;
                buf_rd_sel    <= ld_rd;
                buf_wr_sel    <= ld_wr;
                layer_idx     <= ld_layer;
            end

            // Abort wins over every transition and leaves err and the count untouched.
            if (abort) begin
                state     <= S_IDLE;
                eng_start <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            in_lat      <= cfg_in_depth;
                            out_lat     <= cfg_out_depth;
                            cycle_count <= '0;
                            busy        <= 1'b1;
                            state       <= S_LAUNCH;
`ifdef SCHED_WATCHDOG_EN
                            err         <= 1'b0;
`endif
                        end
                    end
                    S_LAUNCH: begin
                        eng_start <= 1'b1;
                        state     <= S_RUN;
`ifdef SCHED_WATCHDOG_EN
                        wd_cnt    <= '0;
`endif
                    end
                    S_RUN: begin
                        if (eng_done) begin
                            eng_start <= 1'b0;
                            if (is_last) begin
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end else begin
                                state <= S_GAP;
                            end
                        end
`ifdef SCHED_WATCHDOG_EN
                        else if (wd_cnt == WD_LIMIT) begin
                            eng_start <= 1'b0;
                            err       <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_FINISH;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
`endif
                    end
                    S_GAP: begin
                        state <= S_LAUNCH;
                    end
                    S_FINISH: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        eng_start <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
